bus_interconnect: RTL

BUS_INTERCONNECT -- requirements
Module: bus_interconnect

---
 rtl/bus_interconnect.sv | 89 ++++++++
 1 files changed

// File: rtl/bus_interconnect.sv
// bus_interconnect: CPU-to-8-slave request router with registered response and error handling.
// Define BUS_TIMEOUT_EN to abort slave accesses after TIMEOUT_CYCLES active cycles.
module bus_interconnect #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         mem_valid,
  input  logic [3:0]   mem_wstrb,
  input  logic [7:0]   enables,
  output logic [7:0]   slave_valid,
  input  logic [7:0]   slave_ready,
  input  logic [255:0] slave_rdata,
  output logic         mem_ready,
  output logic [31:0]  mem_rdata,
  output logic         bus_error
);
  localparam logic [1:0] IDLE = 2'd0, ACTIVE = 2'd1, RESP = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [7:0]  sel_q, sel_d, slave_valid_q, slave_valid_d;
  logic [31:0] mem_rdata_q, mem_rdata_d, rdata_sel;
  logic        mem_ready_q, bus_error_q, bus_error_d, hit, timeout;
  logic        unused_cfg;
  assign unused_cfg = ^{mem_wstrb, 16'(TIMEOUT_CYCLES)};
  assign hit = |(slave_ready & sel_q);
`ifdef BUS_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = (state_q == ACTIVE) ? cnt_q + 16'd1 : 16'd0;
  assign timeout = (state_q == ACTIVE) && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt_q <= 16'd0;
    else cnt_q <= cnt_d;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    rdata_sel = 32'd0;
    for (int i = 0; i < 8; i++)
      rdata_sel = rdata_sel | (sel_q[i] ? slave_rdata[32*i +: 32] : 32'd0);
  end
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    mem_rdata_d = mem_rdata_q;
    bus_error_d = 1'b0;
    case (state_q)
      IDLE:
        if (mem_valid && |enables) begin
          state_d = ACTIVE;
          sel_d = enables & (~enables + 8'd1);
        end else if (mem_valid) begin
          state_d = RESP;
          mem_rdata_d = 32'd0;
          bus_error_d = 1'b1;
        end
      ACTIVE:
        if (hit) begin
          state_d = RESP;
          mem_rdata_d = rdata_sel;
        end else if (timeout) begin
          state_d = RESP;
          mem_rdata_d = 32'hFFFF_FFFF;
          bus_error_d = 1'b1;
        end
      default: state_d = IDLE;
    endcase
    slave_valid_d = (state_d == ACTIVE) ? sel_d : 8'd0;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      sel_q <= 8'd0;
      slave_valid_q <= 8'd0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'd0;
      bus_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      slave_valid_q <= slave_valid_d;
      mem_ready_q <= (state_d == RESP);
      mem_rdata_q <= mem_rdata_d;
      bus_error_q <= bus_error_d;
    end
  assign slave_valid = slave_valid_q;
  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign bus_error = bus_error_q;
endmodule
